// File: rtl/regfile_context_engine.sv
// Register file context save/restore sequencer: streams r1..r31 out over sv_*, reloads them from rs_*.
// Optional XOR checksum of transferred words is built when CTX_CHECKSUM_EN is defined.
module regfile_context_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             save_req,
  input  logic             restore_req,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [4:0]       rf_ra,
  input  logic [WIDTH-1:0] rf_rd,
  output logic [4:0]       rf_wa,
  output logic [WIDTH-1:0] rf_wd,
  output logic             rf_we,
  output logic [WIDTH-1:0] sv_data,
  output logic             sv_valid,
  input  logic             sv_ready,
  input  logic [WIDTH-1:0] rs_data,
  input  logic             rs_valid,
  output logic             rs_ready,
  output logic [WIDTH-1:0] checksum,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, SAVE = 2'd1, RESTORE = 2'd2} state_t;

  // Streams: a word moves only in a cycle where valid and ready are both high at the rising edge;
  // the producer holds data and valid stable until that happens.
  state_t     state, state_next;
  logic [5:0] idx;
  logic       sv_load, sv_hs, rs_hs, op_done, start;

  assign state_dbg = state;

  always_comb begin
    sv_hs    = (state == SAVE) && sv_valid && sv_ready;
    sv_load  = (state == SAVE) && (idx <= 6'd31) && (!sv_valid || sv_ready);
    rs_hs    = (state == RESTORE) && rs_valid;
    rs_ready = (state == RESTORE);
    rf_ra    = (state == SAVE) ? idx[4:0] : 5'd0;
    rf_we    = rs_hs;
    rf_wa    = rs_hs ? idx[4:0] : 5'd0;
    rf_wd    = rs_hs ? rs_data : '0;
  end

  always_comb begin
    state_next = state;
    op_done    = 1'b0;
    case (state)
      IDLE: begin
        if (save_req)         state_next = SAVE;
        else if (restore_req) state_next = RESTORE;
      end
      SAVE: begin
        // idx reaches 32 once r31 is loaded, so this is the acceptance of the last word
        if (abort) state_next = IDLE;
        else if (sv_hs && idx == 6'd32) begin
          state_next = IDLE;
          op_done    = 1'b1;
        end
      end
      RESTORE: begin
        if (abort) state_next = IDLE;
        else if (rs_hs && idx == 6'd31) begin
          state_next = IDLE;
          op_done    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign start = (state == IDLE) && (state_next != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 6'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sv_valid <= 1'b0;
      sv_data  <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= op_done;
      if (start)                 idx <= 6'd1;
      else if (sv_load || rs_hs) idx <= idx + 6'd1;
      if (state_next == IDLE) sv_valid <= 1'b0;
      else if (sv_load) begin
        sv_data  <= rf_rd;
        sv_valid <= 1'b1;
      end else if (sv_hs) sv_valid <= 1'b0;
    end
  end

`ifdef CTX_CHECKSUM_EN
  logic [WIDTH-1:0] csum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      csum <= '0;
    else if (start) csum <= '0;
    else if (sv_hs) csum <= csum ^ sv_data;
    else if (rs_hs) csum <= csum ^ rs_data;
  end

  assign checksum = csum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_regfile_context_engine.sv
// Bench for regfile_context_engine: register file model, directed save/restore/abort/reset scenarios,
// queue-based scoreboard for save-stream words and register writes.
module tb_regfile_context_engine;

  localparam int WIDTH = 32;
`ifdef CTX_CHECKSUM_EN
  localparam logic [WIDTH-1:0] EXP_SAVE_CS = 32'h1000_0000;
  localparam logic [WIDTH-1:0] EXP_REST_CS = 32'hA5A5_0000;
`else
  localparam logic [WIDTH-1:0] EXP_SAVE_CS = 32'h0;
  localparam logic [WIDTH-1:0] EXP_REST_CS = 32'h0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             save_req = 1'b0, restore_req = 1'b0, abort = 1'b0;
  logic             busy, done, rf_we, sv_valid, rs_ready;
  logic             sv_ready = 1'b0, rs_valid = 1'b0;
  logic [4:0]       rf_ra, rf_wa;
  logic [WIDTH-1:0] rf_rd, rf_wd, sv_data, checksum;
  logic [WIDTH-1:0] rs_data = '0;
  logic [1:0]       state_dbg;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [36:0]      wr_q[$];

  // register file model: combinational read, write on rising edge, preload while preload=1
  logic [WIDTH-1:0] rf [32];
  logic             preload = 1'b1;
  assign rf_rd = rf[rf_ra];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + i;
    end else if (rf_we) rf[rf_wa] <= rf_wd;
  end

  regfile_context_engine #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req), .abort(abort),
    .busy(busy), .done(done), .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_we(rf_we), .sv_data(sv_data), .sv_valid(sv_valid), .sv_ready(sv_ready),
    .rs_data(rs_data), .rs_valid(rs_valid), .rs_ready(rs_ready), .checksum(checksum),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor: pops expected save words and register writes whenever the DUT presents them
  logic             held_v = 1'b0;
  logic [WIDTH-1:0] held_d = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (held_v && sv_valid) chk("sv_stall_hold", sv_data, held_d);
      held_v = sv_valid && !sv_ready;
      held_d = sv_data;
      if (sv_valid && sv_ready) begin
        if (exp_q.size() == 0) chk("sv_extra_word", sv_data, 64'hDEAD);
        else chk("sv_word", sv_data, exp_q.pop_front());
      end
      if (rf_we) begin
        if (wr_q.size() == 0) chk("rf_extra_write", {rf_wa, rf_wd}, 64'hDEAD);
        else chk("rf_write", {rf_wa, rf_wd}, wr_q.pop_front());
      end
    end
  end

  // issue a save and wait for done; exp_edges<0 skips the latency check
  task automatic run_save(input bit alt, input bit both, input int exp_edges);
    int n;
    bit seen;
    for (int i = 1; i <= 31; i++) exp_q.push_back(32'h1000_0000 + i);
    save_req = 1'b1;
    restore_req = both;
    @(posedge clk); #1;
    save_req = 1'b0;
    sv_ready = 1'b1;
    chk("save_busy_at_T", busy, 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && both) chk("both_req_no_restore", rs_ready, 0);
      if (done) seen = 1'b1;
      else if (alt) sv_ready = ~sv_ready;
    end
    restore_req = 1'b0;
    chk("save_done_seen", seen, 1);
    if (exp_edges >= 0) chk("save_done_latency", n, exp_edges);
    chk("save_busy_low_at_done", busy, 0);
    chk("save_checksum", checksum, EXP_SAVE_CS);
    chk("save_queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    sv_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    int k, c;
    bit hs;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sv", {sv_valid, sv_data}, 0);
    chk("rst_rf", {rf_we, rf_ra, rf_wa, rf_wd, rs_ready}, 0);
    chk("rst_checksum", checksum, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    preload = 1'b0;

    run_save(1'b0, 1'b0, 32);
    run_save(1'b1, 1'b0, -1);
    run_save(1'b0, 1'b1, 32);

    // abort after 10 words
    for (int i = 1; i <= 10; i++) exp_q.push_back(32'h1000_0000 + i);
    save_req = 1'b1;
    @(posedge clk); #1;
    save_req = 1'b0;
    sv_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sv_valid", sv_valid, 0);
    chk("abort_done", done, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_late_done", done, 0);
    end
    chk("abort_queue_drained", exp_q.size(), 0);
    sv_ready = 1'b0;

    // restore with gaps in rs_valid
    for (int i = 1; i <= 31; i++) wr_q.push_back({i[4:0], 32'hA5A5_0000 + i});
    pat = 16'b1011_0011_1101_0110;
    restore_req = 1'b1;
    @(posedge clk); #1;
    restore_req = 1'b0;
    chk("restore_busy_at_T", busy, 1);
    k = 1;
    c = 0;
    while (k <= 31 && c < 400) begin
      rs_valid = pat[c % 16];
      rs_data = 32'hA5A5_0000 + k;
      @(negedge clk);
      hs = rs_valid && rs_ready;
      @(posedge clk); #1;
      c++;
      if (hs) begin
        if (k == 31) begin
          chk("restore_done", done, 1);
          chk("restore_busy_low", busy, 0);
        end else if (done) chk("restore_done_early", done, 0);
        k++;
      end
    end
    rs_valid = 1'b0;
    chk("restore_all_words", k, 32);
    chk("restore_checksum", checksum, EXP_REST_CS);
    chk("restore_queue_drained", wr_q.size(), 0);
    chk("restore_r0", rf[0], 0);
    for (int i = 1; i <= 31; i++) chk("restore_rf", rf[i], 32'hA5A5_0000 + i);

    // reset after 5 restored words
    for (int i = 1; i <= 5; i++) wr_q.push_back({i[4:0], 32'h5A5A_0000 + i});
    restore_req = 1'b1;
    @(posedge clk); #1;
    restore_req = 1'b0;
    rs_valid = 1'b1;
    rs_data = 32'h5A5A_0001;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      rs_data = 32'h5A5A_0000 + i + 1;
    end
    rs_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_busy_done", {busy, done}, 0);
    chk("midrst_sv", {sv_valid, sv_data}, 0);
    chk("midrst_rf", {rf_we, rf_ra, rf_wa, rf_wd, rs_ready}, 0);
    chk("midrst_checksum", checksum, 0);
    for (int i = 1; i <= 5; i++) chk("midrst_rf_written", rf[i], 32'h5A5A_0000 + i);
    chk("midrst_r6_kept", rf[6], 32'hA5A5_0006);
    chk("midrst_queue_drained", wr_q.size(), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", {busy, done, rs_ready}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_context_engine.md
# regfile_context_engine

Sequencer that saves and restores the architectural register file (r1..r31) over a pair of valid/ready word streams. It sits beside the register file in the MIPS core and owns the other side of the file's ports during a context switch: it drives the read address and consumes read data to stream registers out, and drives the write port from an incoming stream to reload them. The core is stalled by the surrounding control logic while `busy` is high.

## Interface
- `WIDTH`, 32: register and stream word width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `save_req`  in  1  start save; sampled only in IDLE.
- `restore_req`  in  1  start restore; sampled only in IDLE.
- `abort`  in  1  terminate the current operation.
- `busy`  out  1  high in SAVE or RESTORE.
- `done`  out  1  one-cycle pulse on normal completion.
- `rf_ra`  out  5  register file read address, to A1.
- `rf_rd`  in  WIDTH  register file read data, from RD1 (combinational).
- `rf_wa`  out  5  register file write address, to A3.
- `rf_wd`  out  WIDTH  register file write data, to WD3.
- `rf_we`  out  1  register file write enable, to we3.
- `sv_data`  out  WIDTH  save stream data.
- `sv_valid`  out  1  save stream valid.
- `sv_ready`  in  1  save stream ready.
- `rs_data`  in  WIDTH  restore stream data.
- `rs_valid`  in  1  restore stream valid.
- `rs_ready`  out  1  restore stream ready.
- `checksum`  out  WIDTH  XOR of the words transferred (see Configuration).

## Operation
- States: IDLE, SAVE, RESTORE. Index counter `idx` is 6 bits wide and is set to 1 on entry to SAVE or RESTORE. r0 is never read, streamed or written.
- IDLE: if `save_req`, go to SAVE. Otherwise, if `restore_req`, go to RESTORE. Save wins when both are high. Requests in any other state are ignored.
- SAVE:
  - `rf_ra` = `idx[4:0]`.
  - The output register loads when `idx` ≤ 31 and (`sv_valid`=0 or `sv_ready`=1): `sv_data` <= `rf_rd`, `sv_valid` <= 1, `idx` increments.
  - If the word is accepted with no new load, `sv_valid` <= 0.
  - While `sv_valid`=1 and `sv_ready`=0, `sv_data` and `sv_valid` hold.
  - When the word for r31 is accepted, go to IDLE and pulse `done`.
- RESTORE:
  - `rs_ready` = 1.
  - On `rs_valid`&`rs_ready`: `rf_we`=1, `rf_wa`=`idx[4:0]`, `rf_wd`=`rs_data` (combinational; the file writes at that edge), and `idx` increments.
  - The handshake at `idx`=31 returns to IDLE and pulses `done`.
- `abort` (SAVE or RESTORE): at the next edge go to IDLE, clear `sv_valid`, no `done`. Registers already written stay written.
- In IDLE: `rf_ra`, `rf_wa`, `rf_wd`, `rf_we`, `rs_ready` are 0.
- Reset values: state IDLE, `idx`=0, `busy`=0, `done`=0, `sv_valid`=0, `sv_data`=0, `checksum`=0, all `rf_*` outputs 0, `rs_ready`=0.
- A reset in the middle of an operation behaves like `abort`, and additionally clears `checksum`.

## Timing
- Request sampled at edge T. `busy` is high from T.
- Save: first `sv_valid` from edge T+1. With `sv_ready` held at 1, words r1..r31 appear on cycles T+1..T+31. `done` pulses in the cycle after edge T+32. Sustained throughput is one word per cycle.
- Restore: minimum 31 cycles. r_k is written at the edge of the k-th handshake. `done` follows the 31st handshake by one edge.
- `busy` and `done` are registered. `busy` falls on the same edge that `done` rises.

## Configuration
- `CTX_CHECKSUM_EN` defined:
  - `checksum` is cleared on entry to SAVE or RESTORE.
  - It XOR-accumulates every transferred word: save-stream handshakes in SAVE, restore handshakes in RESTORE.
  - It holds its value in IDLE.
- Not defined: `checksum` is constant 0 and no accumulator is built.

## Test plan
- Preload r_i = 0x1000_0000+i. Save with `sv_ready`=1 -> 31 words in order r1..r31 on consecutive cycles, `done` after edge T+32, `checksum`=0x1000_0000 (macro on).
- Same save with `sv_ready` alternating 1/0 -> `sv_data` stable during stalls, no lost or duplicated words, order preserved.
- Restore 0xA5A5_0000+i with random `rs_valid` gaps -> r1..r31 hold these values, `rf_we` pulses only on handshakes, r0 reads 0, `done` after the 31st word.
- `save_req` and `restore_req` high together -> SAVE entered. `restore_req` during SAVE -> ignored.
- `abort` after 10 saved words -> IDLE next edge, `sv_valid`=0, no `done`. `reset` after 5 restored words -> r1..r5 updated, all outputs 0, `checksum`=0.
- Macro off: repeat the first scenario -> `checksum` remains 0.
